// File: rtl/soc_xbar_pkg.sv
// Shared types and helpers for the SoC contiguous-address crossbar family.
// Rule fields are sized for the widest supported address and port index.
package soc_xbar_pkg;

   localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADACCE5;
   localparam int unsigned RULE_ADDR_W       = 64;
   localparam int unsigned RULE_IDX_W        = 8;

   typedef struct packed {
      logic [RULE_IDX_W-1:0]  idx;
      logic [RULE_ADDR_W-1:0] start_addr;
      logic [RULE_ADDR_W-1:0] end_addr;
   } addr_rule_t;

   // Select width for n ports, never below one bit.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter_lock.sv
// Round-robin arbiter whose priority pointer advances only on a completed handshake,
// so a winner stalled by its target keeps priority until it is served.
module rr_arbiter_lock #(
   parameter int unsigned NR_PORTS = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NR_PORTS-1:0] req,
   input  logic                target_gnt,
   output logic [NR_PORTS-1:0] grant
);
   import soc_xbar_pkg::*;

   localparam int unsigned PW = sel_width(NR_PORTS);

   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   logic [PW-1:0] win_hi;
   logic [PW-1:0] win_lo;
   logic          hit_hi;
   logic          hit_lo;

   // First requester at or after ptr, falling back to the lowest requester on wrap.
   always_comb begin
      hit_hi = 1'b0;
      hit_lo = 1'b0;
      win_hi = '0;
      win_lo = '0;
      grant  = '0;
      for (int j = 0; j < NR_PORTS; j++) begin
         if (req[j] && !hit_lo) begin
            hit_lo = 1'b1;
            win_lo = PW'(j);
         end
         if (req[j] && !hit_hi && (PW'(j) >= ptr)) begin
            hit_hi = 1'b1;
            win_hi = PW'(j);
         end
      end
      win = hit_hi ? win_hi : win_lo;
      for (int j = 0; j < NR_PORTS; j++) begin
         grant[j] = hit_lo && (win == PW'(j));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr <= '0;
      end else if ((|grant) && target_gnt) begin
         ptr <= (win == PW'(NR_PORTS - 1)) ? '0 : win + PW'(1);
      end
   end

endmodule

// File: rtl/contiguous_crossbar_rr.sv
// Contiguous-address crossbar: rule decode, per-slave round-robin arbitration,
// fixed-latency response routing and an internal error responder at index M.
module contiguous_crossbar_rr #(
   parameter int unsigned NR_MASTER_PORTS = 4,
   parameter int unsigned NR_SLAVE_PORTS  = 3,
   parameter int unsigned NR_ADDR_RULES   = 3,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned RESP_LAT        = 1,
   parameter logic [31:0] ERR_RDATA       = soc_xbar_pkg::ERR_RDATA_DEFAULT,
   parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8
) (
   input  logic                                                       clk_i,
   input  logic                                                       rst_i,
   input  logic [NR_MASTER_PORTS-1:0]                                 m_req_i,
   input  logic [NR_MASTER_PORTS-1:0][ADDR_WIDTH-1:0]                 m_add_i,
   input  logic [NR_MASTER_PORTS-1:0]                                 m_wen_i,
   input  logic [NR_MASTER_PORTS-1:0][BE_WIDTH-1:0]                   m_be_i,
   input  logic [NR_MASTER_PORTS-1:0][DATA_WIDTH-1:0]                 m_wdata_i,
   output logic [NR_MASTER_PORTS-1:0]                                 m_gnt_o,
   output logic [NR_MASTER_PORTS-1:0]                                 m_r_valid_o,
   output logic [NR_MASTER_PORTS-1:0][DATA_WIDTH-1:0]                 m_r_rdata_o,
   output logic [NR_MASTER_PORTS-1:0]                                 m_r_opc_o,
   output logic [NR_SLAVE_PORTS-1:0]                                  s_req_o,
   output logic [NR_SLAVE_PORTS-1:0][ADDR_WIDTH-1:0]                  s_add_o,
   output logic [NR_SLAVE_PORTS-1:0]                                  s_wen_o,
   output logic [NR_SLAVE_PORTS-1:0][BE_WIDTH-1:0]                    s_be_o,
   output logic [NR_SLAVE_PORTS-1:0][DATA_WIDTH-1:0]                  s_wdata_o,
   input  logic [NR_SLAVE_PORTS-1:0]                                  s_gnt_i,
   input  logic [NR_SLAVE_PORTS-1:0][DATA_WIDTH-1:0]                  s_r_rdata_i,
   input  logic [NR_SLAVE_PORTS-1:0]                                  s_r_opc_i,
   input  logic [NR_ADDR_RULES-1:0][$clog2(NR_SLAVE_PORTS+1)-1:0]     rule_idx_i,
   input  logic [NR_ADDR_RULES-1:0][ADDR_WIDTH-1:0]                   rule_start_i,
   input  logic [NR_ADDR_RULES-1:0][ADDR_WIDTH-1:0]                   rule_end_i
);
   import soc_xbar_pkg::*;

   localparam int unsigned N  = NR_MASTER_PORTS;
   localparam int unsigned M  = NR_SLAVE_PORTS;
   localparam int unsigned R  = NR_ADDR_RULES;
   localparam int unsigned TW = sel_width(M + 1);
   localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_RDATA);

   addr_rule_t [R-1:0]         rules;
   logic [N-1:0][TW-1:0]       tgt;
   logic                       hit;
   logic [RULE_ADDR_W-1:0]     addr;
   logic [M:0][N-1:0]          cand;
   logic [M:0][N-1:0]          win;
   logic [M:0]                 tgt_gnt;

   always_comb begin
      for (int r = 0; r < R; r++) begin
         rules[r].idx        = RULE_IDX_W'(rule_idx_i[r]);
         rules[r].start_addr = RULE_ADDR_W'(rule_start_i[r]);
         rules[r].end_addr   = RULE_ADDR_W'(rule_end_i[r]);
      end
   end

   // Lowest matching rule wins; an out-of-range slave index falls through to the error slave.
   always_comb begin
      tgt  = '0;
      hit  = 1'b0;
      addr = '0;
      for (int i = 0; i < N; i++) begin
         tgt[i] = TW'(M);
         hit    = 1'b0;
         addr   = RULE_ADDR_W'(m_add_i[i]);
         for (int r = 0; r < R; r++) begin
            if (!hit && (rules[r].start_addr <= addr) && (addr < rules[r].end_addr)) begin
               hit = 1'b1;
               if (rules[r].idx < RULE_IDX_W'(M)) tgt[i] = TW'(rules[r].idx);
            end
         end
      end
   end

   always_comb begin
      cand    = '0;
      tgt_gnt = {1'b1, s_gnt_i};
      for (int t = 0; t <= M; t++) begin
         for (int i = 0; i < N; i++) begin
            cand[t][i] = !rst_i && m_req_i[i] && (tgt[i] == TW'(t));
         end
      end
   end

   for (genvar t = 0; t <= M; t++) begin : g_arb
      rr_arbiter_lock #(
         .NR_PORTS (N)
      ) u_arb (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .req        (cand[t]),
         .target_gnt (tgt_gnt[t]),
         .grant      (win[t])
      );
   end

   always_comb begin
      s_req_o   = '0;
      s_add_o   = '0;
      s_wen_o   = '0;
      s_be_o    = '0;
      s_wdata_o = '0;
      for (int t = 0; t < M; t++) begin
         s_req_o[t] = |win[t];
         for (int i = 0; i < N; i++) begin
            if (win[t][i]) begin
               s_add_o[t]   = m_add_i[i];
               s_wen_o[t]   = m_wen_i[i];
               s_be_o[t]    = m_be_i[i];
               s_wdata_o[t] = m_wdata_i[i];
            end
         end
      end
   end

   always_comb begin
      m_gnt_o = '0;
      for (int t = 0; t <= M; t++) begin
         for (int i = 0; i < N; i++) begin
            if (win[t][i] && tgt_gnt[t]) m_gnt_o[i] = 1'b1;
         end
      end
   end

   // Per-master response tracker: {valid, target} delayed by exactly RESP_LAT cycles.
   for (genvar i = 0; i < N; i++) begin : g_trk
      logic [RESP_LAT-1:0]          vld;
      logic [RESP_LAT-1:0][TW-1:0]  tg;
      logic [DATA_WIDTH-1:0]        rdata;
      logic                         opc;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            vld <= '0;
            tg  <= '0;
         end else begin
            vld[0] <= m_gnt_o[i];
            tg[0]  <= tgt[i];
            for (int s = 1; s < RESP_LAT; s++) begin
               vld[s] <= vld[s-1];
               tg[s]  <= tg[s-1];
            end
         end
      end

      always_comb begin
         rdata = '0;
         opc   = 1'b0;
         if (vld[RESP_LAT-1] && !rst_i) begin
            if (tg[RESP_LAT-1] == TW'(M)) begin
               rdata = ERR_DATA;
               opc   = 1'b1;
            end else begin
               for (int t = 0; t < M; t++) begin
                  if (tg[RESP_LAT-1] == TW'(t)) begin
                     rdata = s_r_rdata_i[t];
                     opc   = s_r_opc_i[t];
                  end
               end
            end
         end
      end

      assign m_r_valid_o[i] = vld[RESP_LAT-1] && !rst_i;
      assign m_r_rdata_o[i] = rdata;
      assign m_r_opc_o[i]   = opc;
   end

endmodule

// File: tb/tb_contiguous_crossbar_rr.sv
// Directed bench: three crossbars (RESP_LAT 1,2,3) share one stimulus stream;
// each step checks the instance whose latency the scenario exercises.
module tb_contiguous_crossbar_rr;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        m_req, m_wen;
   logic [1:0][31:0]  m_add, m_wdata;
   logic [1:0][3:0]   m_be;
   logic [1:0]        s_gnt, s_opc;
   logic [1:0][31:0]  s_rdata;
   logic [1:0][1:0]   rule_idx;
   logic [1:0][31:0]  rule_start, rule_end;

   wire [2:0][1:0]        gnt, rvalid, ropc, s_req, s_wen;
   wire [2:0][1:0][31:0]  rdata, s_add, s_wdata;
   wire [2:0][1:0][3:0]   s_be;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      contiguous_crossbar_rr #(
         .NR_MASTER_PORTS (2),
         .NR_SLAVE_PORTS  (2),
         .NR_ADDR_RULES   (2),
         .DATA_WIDTH      (32),
         .ADDR_WIDTH      (32),
         .RESP_LAT        (k + 1)
      ) u_dut (
         .clk_i        (clk),
         .rst_i        (rst),
         .m_req_i      (m_req),
         .m_add_i      (m_add),
         .m_wen_i      (m_wen),
         .m_be_i       (m_be),
         .m_wdata_i    (m_wdata),
         .m_gnt_o      (gnt[k]),
         .m_r_valid_o  (rvalid[k]),
         .m_r_rdata_o  (rdata[k]),
         .m_r_opc_o    (ropc[k]),
         .s_req_o      (s_req[k]),
         .s_add_o      (s_add[k]),
         .s_wen_o      (s_wen[k]),
         .s_be_o       (s_be[k]),
         .s_wdata_o    (s_wdata[k]),
         .s_gnt_i      (s_gnt),
         .s_r_rdata_i  (s_rdata),
         .s_r_opc_i    (s_opc),
         .rule_idx_i   (rule_idx),
         .rule_start_i (rule_start),
         .rule_end_i   (rule_end)
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rule_idx   = {2'd1, 2'd0};
      rule_start = {32'h2000, 32'h1000};
      rule_end   = {32'h3000, 32'h2000};
      rst = 1'b1; m_req = '0; m_wen = '0; m_add = '0; m_wdata = '0; m_be = '0;
      s_gnt = '0; s_opc = '0; s_rdata = '0;

      // Reset holds every output low even with live requests and slave data.
      cyc();
      m_req = 2'b11; m_add[0] = 32'h1004; m_add[1] = 32'h1004; m_wen = 2'b11;
      m_be = {4'hF, 4'hF}; s_gnt = 2'b11; s_rdata[0] = 32'h11111111; s_opc = 2'b11;
      #1;
      chk("rst_gnt",    32'(gnt[0]),      32'h0);
      chk("rst_sreq",   32'(s_req[0]),    32'h0);
      chk("rst_rvalid", 32'(rvalid[0]),   32'h0);
      chk("rst_rdata",  rdata[0][0],      32'h0);
      chk("rst_opc",    32'(ropc[0]),     32'h0);

      cyc();
      rst = 1'b0; m_req = '0; s_gnt = '0; s_rdata = '0; s_opc = '0;

      // Master0 read to slave0.
      cyc();
      m_req = 2'b01; m_add[0] = 32'h1004; m_wen = 2'b01; s_gnt = 2'b11;
      #1;
      chk("rd_gnt",  32'(gnt[0]),    32'h1);
      chk("rd_sreq", 32'(s_req[0]),  32'h1);
      chk("rd_sadd", s_add[0][0],    32'h1004);
      chk("rd_swen", 32'(s_wen[0]),  32'h1);
      cyc();
      m_req = '0; s_rdata[0] = 32'hCAFE0001;
      #1;
      chk("rd_rvalid",   32'(rvalid[0]), 32'h1);
      chk("rd_rdata",    rdata[0][0],    32'hCAFE0001);
      chk("rd_opc",      32'(ropc[0]),   32'h0);
      chk("rd_lat2_idle", 32'(rvalid[1]), 32'h0);

      // Master1 write to unmapped 0x3000 hits the error responder.
      cyc();
      s_rdata = '0; m_req = 2'b10; m_add[1] = 32'h3000; m_wen = 2'b00; m_wdata[1] = 32'h55;
      #1;
      chk("err_gnt",    32'(gnt[0]),    32'h2);
      chk("err_sreq",   32'(s_req[0]),  32'h0);
      chk("err_rv_pre", 32'(rvalid[0]), 32'h0);
      cyc();
      m_req = '0;
      #1;
      chk("err_rvalid", 32'(rvalid[0]), 32'h2);
      chk("err_rdata",  rdata[0][1],    32'hBADACCE5);
      chk("err_opc",    32'(ropc[0]),   32'h2);

      // 0x2FFF is the last byte of slave1.
      cyc();
      m_req = 2'b10; m_add[1] = 32'h2FFF; m_wen = 2'b10;
      #1;
      chk("edge_sreq", 32'(s_req[0]), 32'h2);
      chk("edge_gnt",  32'(gnt[0]),   32'h2);
      cyc();
      m_req = '0; s_rdata[1] = 32'h12345678;
      #1;
      chk("edge_rvalid", 32'(rvalid[0]), 32'h2);
      chk("edge_rdata",  rdata[0][1],    32'h12345678);
      chk("edge_opc",    32'(ropc[0]),   32'h0);

      // Continuous contention on slave1 alternates M0, M1, M0, M1.
      for (int k = 0; k < 4; k++) begin
         cyc();
         s_rdata = '0; m_req = 2'b11; m_add[0] = 32'h2000; m_add[1] = 32'h2000; s_gnt = 2'b10;
         #1;
         chk("rr_gnt", 32'(gnt[0]), (k % 2 == 0) ? 32'h1 : 32'h2);
      end

      // Lone M1 access leaves slave0's pointer at 0.
      cyc();
      m_req = 2'b10; m_add[1] = 32'h1008; s_gnt = 2'b01;
      #1;
      chk("prep_gnt", 32'(gnt[0]), 32'h2);

      // Slave0 stalls 3 cycles: no grants, M0 stays the presented winner.
      for (int k = 0; k < 3; k++) begin
         cyc();
         m_req = 2'b11; m_add[0] = 32'h1000; m_add[1] = 32'h1010; s_gnt = 2'b00;
         #1;
         chk("stall_gnt",  32'(gnt[0]),   32'h0);
         chk("stall_sreq", 32'(s_req[0]), 32'h1);
         chk("stall_sadd", s_add[0][0],   32'h1000);
      end
      cyc();
      s_gnt = 2'b01;
      #1;
      chk("unstall_gnt0", 32'(gnt[0]), 32'h1);
      cyc();
      #1;
      chk("unstall_gnt1", 32'(gnt[0]), 32'h2);

      cyc(); m_req = '0;
      cyc();
      cyc();

      // RESP_LAT=3: four back-to-back reads, four in-order responses from cycle 3.
      for (int k = 0; k < 8; k++) begin
         cyc();
         m_req = (k < 4) ? 2'b01 : 2'b00;
         m_add[0] = 32'h1000 + 32'(4 * k); m_wen = 2'b01; s_gnt = 2'b01;
         s_rdata[0] = (k >= 3 && k < 7) ? 32'hD00 + 32'(k - 3) : 32'h0;
         #1;
         chk("b2b_gnt",    32'(gnt[2]),    (k < 4) ? 32'h1 : 32'h0);
         chk("b2b_rvalid", 32'(rvalid[2]), (k >= 3 && k < 7) ? 32'h1 : 32'h0);
         if (k >= 3 && k < 7) chk("b2b_rdata", rdata[2][0], 32'hD00 + 32'(k - 3));
      end

      // Grant then reset: in-flight responses are dropped, pointer returns to M0.
      cyc();
      m_req = 2'b01; m_add[0] = 32'h1000; s_gnt = 2'b01; s_rdata = '0;
      #1;
      chk("mid_gnt", 32'(gnt[1]), 32'h1);
      cyc();
      rst = 1'b1; m_req = 2'b11; m_add[1] = 32'h1000; s_gnt = 2'b11;
      s_rdata[0] = 32'hFFFF0000; s_opc = 2'b11;
      #1;
      chk("mid_rst_gnt",    32'(gnt[1]),    32'h0);
      chk("mid_rst_sreq",   32'(s_req[1]),  32'h0);
      chk("mid_rst_rv_l1",  32'(rvalid[0]), 32'h0);
      chk("mid_rst_rdata",  rdata[0][0],    32'h0);
      chk("mid_rst_opc",    32'(ropc[0]),   32'h0);
      cyc();
      #1;
      chk("mid_rst_rv_l2",  32'(rvalid[1]), 32'h0);
      cyc();
      rst = 1'b0; m_req = 2'b11; s_gnt = 2'b01; s_opc = '0; s_rdata = '0;
      #1;
      chk("post_rst_rv_l3", 32'(rvalid[2]), 32'h0);
      chk("post_rst_gnt",   32'(gnt[0]),    32'h1);
      cyc();
      m_req = '0;
      #1;
      chk("post_rst_rv_l2", 32'(rvalid[1]), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
